// File: rtl/serial_word_assembler.sv
// Collects an LSB-first serial bit stream (plus final carry) into a parallel word
// and presents it on a valid/ready port.
module serial_word_assembler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_start,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_carry,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] sreg_shift;
    logic [WIDTH-1:0] sreg_first;
    logic             restart;

    assign sreg_shift = {in_bit, sreg_q[WIDTH-1:1]};
    assign sreg_first = {in_bit, {(WIDTH - 1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sreg_q    <= '0;
            data_q    <= '0;
            carry_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            data_q    <= data_d;
            carry_q   <= carry_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        data_d    = data_q;
        carry_d   = carry_q;
        overrun_d = overrun_q;
        restart   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_start) begin
                    restart = 1'b1;
                end else if (in_valid) begin
                    overrun_d = 1'b1;
                end
            end
            StShift: begin
                if (in_start) begin
                    restart = 1'b1;
                end else if (in_valid) begin
                    sreg_d = sreg_shift;
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        data_d  = sreg_shift;
                        carry_d = in_carry;
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                    restart = in_start;
                end else if (in_start || in_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new word may begin with its bit 0 on the same cycle; WIDTH >= 2 so it never completes here.
        if (restart) begin
            state_d = StShift;
            cnt_d   = in_valid ? CW'(1) : '0;
            sreg_d  = in_valid ? sreg_first : '0;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = (state_q == StHold);
        out_data  = data_q;
        out_carry = carry_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed self-checking bench for serial_word_assembler (WIDTH = 8).
module tb_serial_word_assembler;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_start;
    logic             in_valid;
    logic             in_bit;
    logic             in_carry;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             overrun;

    int vectors;
    int miscompares;

    serial_word_assembler #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_carry  (in_carry),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are applied 1 time unit after a rising edge, held across the next edge,
    // and outputs are observed 1 time unit after that edge.
    task automatic drive(input logic s, input logic v, input logic b, input logic c);
        in_start = s;
        in_valid = v;
        in_bit   = b;
        in_carry = c;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_carry = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic c);
        drive(1'b1, 1'b1, w[0], 1'b0);
        for (int i = 1; i < WIDTH; i++) begin
            drive(1'b0, 1'b1, w[i], (i == WIDTH - 1) ? c : 1'b0);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if ({busy, out_valid, out_carry, overrun} !== 4'b0000 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b valid=%b carry=%b overrun=%b data=%h, required all 0",
                     busy, out_valid, out_carry, overrun, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] w;
        w = 8'hA5;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, w[0], 1'b0);
        for (int i = 1; i < WIDTH; i++) begin
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_shifting bit %0d: valid=%b busy=%b, required valid=0 busy=1",
                         i, out_valid, busy);
            end
            drive(1'b0, 1'b1, w[i], (i == WIDTH - 1) ? 1'b1 : 1'b0);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_carry !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_word: valid=%b data=%h carry=%b overrun=%b, required 1 a5 1 0",
                     out_valid, out_data, out_carry, overrun);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_after_transfer: valid=%b busy=%b data=%h, required 0 0 a5",
                     out_valid, busy, out_data);
        end
    endtask

    task automatic test_gaps();
        logic [WIDTH-1:0] w;
        int gaps [WIDTH];
        gaps = '{0, 2, 3, 1, 0, 3, 2, 1};
        w = 8'h3C;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, w[0], 1'b0);
        for (int i = 1; i < WIDTH; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                drive(1'b0, 1'b0, 1'b1, 1'b1);
                vectors++;
                if (out_valid !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gaps_hold bit %0d gap %0d: valid=%b busy=%b, required 0 1",
                             i, g, out_valid, busy);
                end
            end
            drive(1'b0, 1'b1, w[i], 1'b0);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_word: valid=%b data=%h carry=%b, required 1 3c 0",
                     out_valid, out_data, out_carry);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_word(8'hFF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
                miscompares++;
                $display("FAIL overrun_hold cycle %0d: valid=%b data=%h, required 1 ff",
                         k, out_valid, out_data);
            end
        end
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: overrun=%b, required 1", overrun);
        end
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: valid=%b overrun=%b, required 0 1", out_valid, overrun);
        end
        send_word(8'h01, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_next_word: valid=%b data=%h overrun=%b, required 1 01 1",
                     out_valid, out_data, overrun);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        pulse_rst();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_partial: busy=%b valid=%b, required 1 0", busy, out_valid);
        end
        send_word(8'h81, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h81 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_word: valid=%b data=%h overrun=%b, required 1 81 0",
                     out_valid, out_data, overrun);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w;
        int n;
        w = 8'h5A;
        n = 0;
        out_ready = 1'b1;
        send_word(8'h12, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h12) begin
            miscompares++;
            $display("FAIL b2b_first: valid=%b data=%h, required 1 12", out_valid, out_data);
        end
        drive(1'b1, 1'b1, w[0], 1'b0);
        n++;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || out_data !== 8'h12) begin
            miscompares++;
            $display("FAIL b2b_transfer: valid=%b busy=%b data=%h, required 0 1 12",
                     out_valid, busy, out_data);
        end
        for (int i = 1; i < WIDTH; i++) begin
            drive(1'b0, 1'b1, w[i], 1'b1);
            n++;
            if (i == WIDTH - 2) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_early_valid: valid=%b after %0d cycles, required 0",
                             out_valid, n);
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_carry !== 1'b1 || n != WIDTH) begin
            miscompares++;
            $display("FAIL b2b_second: valid=%b data=%h carry=%b cycles=%0d, required 1 5a 1 %0d",
                     out_valid, out_data, out_carry, n, WIDTH);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rst();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, out_valid, out_carry, overrun} !== 4'b0000 || out_data !== '0) begin
            miscompares++;
            $display("FAIL rst_shift: busy=%b valid=%b carry=%b overrun=%b data=%h, required all 0",
                     busy, out_valid, out_carry, overrun, out_data);
        end
        rst = 1'b0;
        #1;
        out_ready = 1'b0;
        send_word(8'hC3, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_carry !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_prehold: valid=%b data=%h carry=%b, required 1 c3 1",
                     out_valid, out_data, out_carry);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, out_valid, out_carry, overrun} !== 4'b0000 || out_data !== '0) begin
            miscompares++;
            $display("FAIL rst_hold: busy=%b valid=%b carry=%b overrun=%b data=%h, required all 0",
                     busy, out_valid, out_carry, overrun, out_data);
        end
        rst = 1'b0;
        #1;
        out_ready = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stray_valid: overrun=%b busy=%b, required 1 0", overrun, busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_start    = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        in_carry    = 1'b0;
        out_ready   = 1'b1;
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
